// File: rtl/ram_port_arbiter_if.sv
// Bus bundle for ram_port_arbiter: two requester command channels, the
// read-response channel and the RAM-side command/data strobes.
// slave modport = arbiter side, master modport = requesters + RAM model side.
interface ram_port_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [9:0] req0_din;
    logic       req1_valid;
    logic       req1_ready;
    logic [9:0] req1_din;
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;

    modport slave (
        input  req0_valid, req0_din, req1_valid, req1_din, ram_dout, ram_tx_valid,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, ram_din, ram_rx_valid
    );

    modport master (
        output req0_valid, req0_din, req1_valid, req1_din, ram_dout, ram_tx_valid,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, ram_din, ram_rx_valid
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one RAM command port between
// two requesters. Each requester owns private write/read address registers;
// address opcodes (00/10) complete in one cycle, data opcodes (01/11) issue an
// address word then a data word to the RAM, reads then wait for the RAM reply.
// Optional feature: define RAM_ARB_AUTO_INC_EN to post-increment the owning
// address register (modulo MEM_DEPTH) after each completed data access.
module ram_port_arbiter #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic              clk,
    input  logic              rst,
    ram_port_arbiter_if.slave bus
);

`ifdef RAM_ARB_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    localparam logic [1:0] OP_WA = 2'b00;
    localparam logic [1:0] OP_WD = 2'b01;
    localparam logic [1:0] OP_RA = 2'b10;
    localparam logic [1:0] OP_RD = 2'b11;

    typedef enum logic [1:0] {IDLE, SET_ADDR, XFER, WAIT_RD} state_t;

    // Next address with wrap at the last RAM word.
    function automatic logic [ADDR_SIZE-1:0] f_next_addr(input logic [ADDR_SIZE-1:0] a);
        if (a == ADDR_SIZE'(MEM_DEPTH - 1)) return '0;
        return a + 1'b1;
    endfunction

    state_t                r_state;
    logic                  r_last;
    logic [ADDR_SIZE-1:0]  r_wr_addr [2];
    logic [ADDR_SIZE-1:0]  r_rd_addr [2];
    logic                  r_id;
    logic                  r_is_rd;
    logic [7:0]            r_payload;
    logic                  r_rsp_valid;
    logic                  r_rsp_id;
    logic [7:0]            r_rsp_data;
    logic [9:0]            r_ram_din;
    logic                  r_ram_rx_valid;

    logic                  w_idle;
    logic                  w_gnt_vld;
    logic                  w_gnt;
    logic                  w_xfer;
    logic [9:0]            w_din;

    assign w_idle = (r_state == IDLE);

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_gnt_vld = 1'b1;
            w_gnt     = ~r_last;
        end else if (bus.req0_valid) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b0;
        end else if (bus.req1_valid) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b1;
        end
    end

    // Ready is only offered in IDLE and only to a valid, granted requester,
    // so a grant in IDLE is always a completed handshake.
    assign w_xfer         = w_idle && w_gnt_vld;
    assign w_din          = w_gnt ? bus.req1_din : bus.req0_din;
    assign bus.req0_ready = w_xfer && !w_gnt;
    assign bus.req1_ready = w_xfer &&  w_gnt;

    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_id       = r_rsp_id;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.ram_din      = r_ram_din;
    assign bus.ram_rx_valid = r_ram_rx_valid;

    // Control FSM with registered RAM/response outputs; each state names the
    // cycle in which its RAM word is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_last         <= 1'b1;
            r_wr_addr      <= '{default: '0};
            r_rd_addr      <= '{default: '0};
            r_id           <= 1'b0;
            r_is_rd        <= 1'b0;
            r_payload      <= 8'h00;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_data     <= 8'h00;
            r_ram_din      <= 10'h000;
            r_ram_rx_valid <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_last <= w_gnt;
                        case (w_din[9:8])
                            OP_WA: r_wr_addr[w_gnt] <= ADDR_SIZE'(w_din[7:0]);
                            OP_RA: r_rd_addr[w_gnt] <= ADDR_SIZE'(w_din[7:0]);
                            default: begin
                                r_id           <= w_gnt;
                                r_is_rd        <= w_din[9];
                                r_payload      <= w_din[7:0];
                                r_ram_din      <= w_din[9] ? {OP_RA, 8'(r_rd_addr[w_gnt])}
                                                           : {OP_WA, 8'(r_wr_addr[w_gnt])};
                                r_ram_rx_valid <= 1'b1;
                                r_state        <= SET_ADDR;
                            end
                        endcase
                    end
                end
                SET_ADDR: begin
                    r_ram_din <= r_is_rd ? {OP_RD, 8'h00} : {OP_WD, r_payload};
                    r_state   <= XFER;
                end
                XFER: begin
                    r_ram_din      <= 10'h000;
                    r_ram_rx_valid <= 1'b0;
                    if (r_is_rd) begin
                        r_state <= WAIT_RD;
                    end else begin
                        r_state <= IDLE;
                        if (AUTO_INC) r_wr_addr[r_id] <= f_next_addr(r_wr_addr[r_id]);
                    end
                end
                WAIT_RD: begin
                    if (bus.ram_tx_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_data  <= bus.ram_dout;
                        r_state     <= IDLE;
                        if (AUTO_INC) r_rd_addr[r_id] <= f_next_addr(r_rd_addr[r_id]);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed commands push the expected
// RAM words and read responses into queues; a negedge monitor pops and
// compares whenever the DUT strobes ram_rx_valid or rsp_valid.
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    logic [9:0] ram_q [$];
    logic [8:0] rsp_q [$];

`ifdef RAM_ARB_AUTO_INC_EN
    localparam logic [9:0] E_ADDR2 = 10'h000;
`else
    localparam logic [9:0] E_ADDR2 = 10'h0FF;
`endif

    ram_port_arbiter_if bus ();

    ram_port_arbiter #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitor: pop the scoreboard on every DUT strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ram_rx_valid) begin
                if (ram_q.size() == 0)
                    fail("ram_unexpected", $sformatf("got ram_din 0x%0h, expected no RAM access", bus.ram_din));
                else
                    chk("ram_din", {22'b0, bus.ram_din}, {22'b0, ram_q.pop_front()});
            end else begin
                chk("ram_din_idle", {22'b0, bus.ram_din}, 32'h0);
            end
            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0)
                    fail("rsp_unexpected", $sformatf("got rsp id %0d data 0x%0h, expected none", bus.rsp_id, bus.rsp_data));
                else
                    chk("rsp_id_data", {23'b0, bus.rsp_id, bus.rsp_data}, {23'b0, rsp_q.pop_front()});
            end
        end
    end

    task automatic drive(input bit id, input logic [1:0] op, input logic [7:0] pl);
        if (id) begin
            bus.req1_valid = 1'b1;
            bus.req1_din   = {op, pl};
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_din   = {op, pl};
        end
    endtask

    task automatic release_req(input bit id);
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    // Wait (bounded) for this requester's handshake, then drop its valid.
    task automatic wait_acc(input bit id, input string name);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (n < 40 && !ok) begin
            @(negedge clk);
            ok = id ? bus.req1_ready : bus.req0_ready;
            n++;
        end
        if (!ok) fail(name, "got no accept within 40 cycles, expected ready");
        @(posedge clk); #1;
        release_req(id);
    endtask

    task automatic send(input bit id, input logic [1:0] op, input logic [7:0] pl, input string name);
        drive(id, op, pl);
        wait_acc(id, name);
    endtask

    task automatic tx_pulse(input logic [7:0] d);
        @(posedge clk); #1;
        bus.ram_dout     = d;
        bus.ram_tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.ram_tx_valid = 1'b0;
        bus.ram_dout     = 8'h00;
    endtask

    initial begin
        bus.req0_valid   = 1'b0;
        bus.req0_din     = 10'h0;
        bus.req1_valid   = 1'b0;
        bus.req1_din     = 10'h0;
        bus.ram_dout     = 8'h00;
        bus.ram_tx_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_din",      {22'b0, bus.ram_din}, 32'h0);
        chk("rst_ram_rx_valid", {31'b0, bus.ram_rx_valid}, 32'h0);
        chk("rst_rsp_valid",    {31'b0, bus.rsp_valid}, 32'h0);
        chk("rst_rsp_id",       {31'b0, bus.rsp_id}, 32'h0);
        chk("rst_rsp_data",     {24'b0, bus.rsp_data}, 32'h0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Write address then write data from requester 0, ready gap check.
        send(0, 2'b00, 8'h0F, "acc_a0");
        ram_q.push_back(10'h00F);
        ram_q.push_back(10'h10A);
        drive(0, 2'b01, 8'h0A);
        wait_acc(0, "acc_a1");
        drive(0, 2'b00, 8'h0F);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("a_ready_c%0d", i), {31'b0, bus.req0_ready}, (i == 3) ? 32'h1 : 32'h0);
            chk($sformatf("a_rx_valid_c%0d", i), {31'b0, bus.ram_rx_valid}, (i == 3) ? 32'h0 : 32'h1);
        end
        @(posedge clk); #1;
        release_req(0);

        // RAM reply strobe while idle must be ignored.
        tx_pulse(8'h5A);

        // Read from requester 1 with a delayed RAM reply.
        send(1, 2'b10, 8'h0F, "acc_b0");
        ram_q.push_back(10'h20F);
        ram_q.push_back(10'h300);
        rsp_q.push_back({1'b1, 8'hA5});
        send(1, 2'b11, 8'h00, "acc_b1");
        repeat (6) @(posedge clk);
        #1;
        bus.ram_dout     = 8'hA5;
        bus.ram_tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.ram_tx_valid = 1'b0;
        bus.ram_dout     = 8'h00;
        @(negedge clk);
        chk("b_rsp_pulse_on", {31'b0, bus.rsp_valid}, 32'h1);
        @(negedge clk);
        chk("b_rsp_pulse_off", {31'b0, bus.rsp_valid}, 32'h0);

        // Both requesters stream write-address commands: grants alternate.
        @(posedge clk); #1;
        drive(0, 2'b00, 8'h11);
        drive(1, 2'b00, 8'h22);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("c_grant%0d", i), {30'b0, bus.req1_ready, bus.req0_ready},
                (i % 2 == 0) ? 32'h1 : 32'h2);
            @(posedge clk); #1;
        end
        release_req(0);
        release_req(1);
        ram_q.push_back(10'h011);
        ram_q.push_back(10'h133);
        send(0, 2'b01, 8'h33, "acc_c0");
        ram_q.push_back(10'h022);
        ram_q.push_back(10'h144);
        send(1, 2'b01, 8'h44, "acc_c1");

        // Contending writes each use their own requester's address.
        send(0, 2'b00, 8'h10, "acc_d0");
        send(1, 2'b00, 8'h20, "acc_d1");
        ram_q.push_back(10'h010);
        ram_q.push_back(10'h1AA);
        ram_q.push_back(10'h020);
        ram_q.push_back(10'h1BB);
        drive(0, 2'b01, 8'hAA);
        drive(1, 2'b01, 8'hBB);
        wait_acc(0, "acc_d2");
        wait_acc(1, "acc_d3");

        // Two writes from the top address.
        send(0, 2'b00, 8'hFF, "acc_e0");
        ram_q.push_back(10'h0FF);
        ram_q.push_back(10'h101);
        send(0, 2'b01, 8'h01, "acc_e1");
        ram_q.push_back(E_ADDR2);
        ram_q.push_back(10'h102);
        send(0, 2'b01, 8'h02, "acc_e2");

        // Reset while waiting for read data.
        send(1, 2'b10, 8'h40, "acc_f0");
        ram_q.push_back(10'h240);
        ram_q.push_back(10'h300);
        send(1, 2'b11, 8'h00, "acc_f1");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("f_rx_after_rst",  {31'b0, bus.ram_rx_valid}, 32'h0);
        chk("f_rsp_after_rst", {31'b0, bus.rsp_valid}, 32'h0);
        tx_pulse(8'h77);
        @(negedge clk);
        chk("f_rsp_ignored", {31'b0, bus.rsp_valid}, 32'h0);

        // After reset requester 0 wins the first contended grant.
        @(posedge clk); #1;
        drive(0, 2'b10, 8'h00);
        drive(1, 2'b10, 8'h00);
        @(negedge clk);
        chk("f_first_grant", {30'b0, bus.req1_ready, bus.req0_ready}, 32'h1);
        @(posedge clk); #1;
        release_req(0);
        @(negedge clk);
        chk("f_second_grant", {30'b0, bus.req1_ready, bus.req0_ready}, 32'h2);
        @(posedge clk); #1;
        release_req(1);

        // Requester 1 write address was cleared by reset.
        ram_q.push_back(10'h000);
        ram_q.push_back(10'h177);
        send(1, 2'b01, 8'h77, "acc_f2");

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("ram_q_drained", ram_q.size(), 32'h0);
        chk("rsp_q_drained", rsp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
        $fatal(1);
    end

endmodule
